// File: rtl/disp_pkg.sv
// Shared constants and types for the display scan controller.
package disp_pkg;

    // Display mode codes understood by the downstream segment decoder.
    localparam logic [2:0] MODE_DEC = 3'b000;
    localparam logic [2:0] MODE_NEG = 3'b001;
    localparam logic [2:0] MODE_ERR = 3'b010;
    localparam logic [2:0] MODE_DP  = 3'b100;

    localparam int DIGITS = 4;

    typedef enum logic {SHOW, BLANK} scan_state_e;

endpackage

// File: rtl/disp_scan_if.sv
// Core-to-display bus: load strobe with value/mode, and the scan outputs.
interface disp_scan_if;
    import disp_pkg::*;

    logic              load;
    logic [7:0]        data_in;
    logic [2:0]        mode_in;
    logic [DIGITS-1:0] anodes;
    logic [7:0]        data;
    logic [2:0]        contr;
    logic              pending;
    logic              frame_tick;

    // Calculator core side
    modport master (output load, data_in, mode_in,
                    input  anodes, data, contr, pending, frame_tick);

    // Scan controller side
    modport slave  (input  load, data_in, mode_in,
                    output anodes, data, contr, pending, frame_tick);
endinterface

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the slot end and the
// point where the blanking gap begins.
module scan_tick_gen #(
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic blank_start
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(DIV - 1 - BLANK_CYCLES);

    logic [CW-1:0] cnt;

    assign slot_end    = (cnt == LAST);
    assign blank_start = (cnt == BLK);

    // Slot counter, wraps at the end of each digit slot
    always_ff @(posedge clk) begin
        if (rst)           cnt <= '0;
        else if (slot_end) cnt <= '0;
        else               cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/disp_scan.sv
// Multiplexed 4-digit display scan controller. Loads are held pending and
// applied only on the digit 3->0 edge so a number never tears mid-frame.
// Optional inter-digit blanking: define DISP_SCAN_BLANK_EN.
module disp_scan
    import disp_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input logic         clk,
    input logic         rst,
    disp_scan_if.slave  bus
);
    localparam int DW = $clog2(DIGITS);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

    logic              slot_end;
    logic              blank_start;
    logic [DW-1:0]     digit;
    logic              boundary;
    logic [DIGITS-1:0] anodes_c;

    logic [7:0] data_q, pend_data;
    logic [2:0] contr_q, pend_mode;
    logic       pend_q, tick_q;

    scan_tick_gen #(.DIV(DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_tick (
        .clk         (clk),
        .rst         (rst),
        .slot_end    (slot_end),
        .blank_start (blank_start)
    );

    assign boundary = slot_end && (digit == LAST_DIGIT);

    // Digit index advances at the end of every slot
    always_ff @(posedge clk) begin
        if (rst)           digit <= '0;
        else if (slot_end) digit <= digit + 1'b1;
    end

`ifdef DISP_SCAN_BLANK_EN
    scan_state_e state, state_nxt;

    // Scan state register
    always_ff @(posedge clk) begin
        if (rst) state <= SHOW;
        else     state <= state_nxt;
    end

    // Blank the anodes for the tail of each slot to suppress ghosting
    always_comb begin
        state_nxt = state;
        anodes_c  = '0;
        case (state)
            SHOW: begin
                anodes_c = DIGITS'(1) << digit;
                if (blank_start) state_nxt = BLANK;
            end
            BLANK: begin
                if (slot_end) state_nxt = SHOW;
            end
            default: state_nxt = SHOW;
        endcase
    end
`else
    logic unused_blank;
    assign unused_blank = blank_start;

    // Anodes follow the digit index directly, no gap between digits
    always_comb begin
        anodes_c = DIGITS'(1) << digit;
    end
`endif

    // Load capture and frame-boundary commit; a load on the boundary wins
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            contr_q   <= MODE_DEC;
            pend_q    <= 1'b0;
            pend_data <= '0;
            pend_mode <= MODE_DEC;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= boundary;
            if (boundary) begin
                if (bus.load) begin
                    data_q  <= bus.data_in;
                    contr_q <= bus.mode_in;
                end else if (pend_q) begin
                    data_q  <= pend_data;
                    contr_q <= pend_mode;
                end
                pend_q <= 1'b0;
            end else if (bus.load) begin
                pend_data <= bus.data_in;
                pend_mode <= bus.mode_in;
                pend_q    <= 1'b1;
            end
        end
    end

    assign bus.anodes     = anodes_c;
    assign bus.data       = data_q;
    assign bus.contr      = contr_q;
    assign bus.pending    = pend_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_disp_scan.sv
// Randomized self-checking bench for disp_scan against a frame-level model.
module tb_disp_scan;
    import disp_pkg::*;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = DIGITS * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    disp_scan_if bus();

    disp_scan #(.DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycles since reset plus committed/pending values
    int         t;
    logic [7:0] m_data, m_pdata;
    logic [2:0] m_contr, m_pmode;
    logic       m_pend, m_tick;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic int exp_anodes(input int tc);
        int slot, pos;
        slot = (tc / DIV) % DIGITS;
        pos  = tc % DIV;
`ifdef DISP_SCAN_BLANK_EN
        if (pos >= DIV - BLANK) return 0;
`endif
        return 1 << slot;
    endfunction

    task automatic model_edge(input logic r, input logic ld, input logic [7:0] d,
                              input logic [2:0] m);
        logic bnd;
        if (r) begin
            t = 0; m_data = 0; m_contr = 0; m_pend = 0; m_tick = 0;
            m_pdata = 0; m_pmode = 0;
        end else begin
            bnd = ((t % FRAME) == FRAME - 1);
            m_tick = bnd;
            if (bnd) begin
                if (ld) begin m_data = d; m_contr = m; end
                else if (m_pend) begin m_data = m_pdata; m_contr = m_pmode; end
                m_pend = 0;
            end else if (ld) begin
                m_pdata = d; m_pmode = m; m_pend = 1;
            end
            t++;
        end
    endtask

    task automatic check_all();
        chk("anodes",     int'(bus.anodes), exp_anodes(t));
        chk("onehot",     int'($countones(bus.anodes) <= 1), 1);
        chk("data",       int'(bus.data), int'(m_data));
        chk("contr",      int'(bus.contr), int'(m_contr));
        chk("pending",    int'(bus.pending), int'(m_pend));
        chk("frame_tick", int'(bus.frame_tick), int'(m_tick));
    endtask

    // One clock: drive inputs, let the edge happen, compare at the falling edge
    task automatic step(input logic r, input logic ld, input logic [7:0] d,
                        input logic [2:0] m);
        rst = r; bus.load = ld; bus.data_in = d; bus.mode_in = m;
        @(posedge clk);
        model_edge(r, ld, d, m);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 8'hAA, 3'b111);   // load alongside reset is dropped
        step(1'b1, 1'b0, 8'h00, 3'b000);
    endtask

    initial begin
        bus.load = 1'b0; bus.data_in = '0; bus.mode_in = '0;
        t = 0; m_data = 0; m_contr = 0; m_pend = 0; m_tick = 0;
        m_pdata = 0; m_pmode = 0;

        // Reset scan and deferred load of 123 at cycle 5
        do_reset();
        for (int c = 0; c < 20; c++)
            step(1'b0, c == 5, 8'd123, MODE_DEC);

        // Boundary coincidence with last-wins: 7 at cycle 2, 200/NEG at 15
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c == 2)       step(1'b0, 1'b1, 8'd7,   MODE_DEC);
            else if (c == 15) step(1'b0, 1'b1, 8'd200, MODE_NEG);
            else              step(1'b0, 1'b0, 8'd0,   MODE_DEC);
        end
        chk("boundary_data", int'(bus.data), 200);

        // Mid-operation reset discards a pending 42
        do_reset();
        for (int c = 0; c < 24; c++)
            step(c == 9, c == 3, 8'd42, MODE_ERR);

        // Random loads, modes (including undefined codes) and occasional reset
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            logic r, ld;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 5) == 0);
            step(r, ld, 8'($urandom), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
